regfile_write_arbiter: RTL and testbench

//   Writer side of the register-file write port. Merges writeback requests

---
 rtl/regfile_write_arbiter.sv | 174 +++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_arbiter
//  Purpose  : Merges ALU and LSU writebacks into one register-file write port
//             through per-source FIFOs and a round-robin arbiter.
//  Options  : REGFILE_WR_BYPASS_EN builds the forwarding / pending compare logic
//  Revision : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_data,
    output logic          write_en,
    output logic [AW-1:0] writereg_addr,
    output logic [DW-1:0] write_data,
    output logic          busy,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic          fwd_hit1,
    output logic          fwd_hit2,
    output logic [DW-1:0] fwd_data1,
    output logic [DW-1:0] fwd_data2,
    output logic          pend1,
    output logic          pend2
);
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    // Index 0 is the ALU source, index 1 the LSU source.
    logic [AW-1:0]   r_mem_addr [2][DEPTH];
    logic [DW-1:0]   r_mem_data [2][DEPTH];
    logic [c_PW-1:0] r_wr_ptr   [2];
    logic [c_PW-1:0] r_rd_ptr   [2];
    logic [c_CW-1:0] r_cnt      [2];
    logic            r_rr_lsu_last;
    logic            r_write_en;
    logic [AW-1:0]   r_wr_addr;
    logic [DW-1:0]   r_wr_data;

    logic [AW-1:0]   w_in_addr [2];
    logic [DW-1:0]   w_in_data [2];
    logic [1:0]      w_valid;
    logic [1:0]      w_ready;
    logic [1:0]      w_nempty;
    logic [1:0]      w_push;
    logic [1:0]      w_pop;
    logic [AW-1:0]   w_head_addr;
    logic [DW-1:0]   w_head_data;

    assign w_in_addr[0] = alu_addr;
    assign w_in_addr[1] = lsu_addr;
    assign w_in_data[0] = alu_data;
    assign w_in_data[1] = lsu_data;
    assign w_valid      = {lsu_valid, alu_valid};
    assign w_ready      = {r_cnt[1] != c_FULL, r_cnt[0] != c_FULL};
    assign w_nempty     = {r_cnt[1] != '0, r_cnt[0] != '0};
    assign w_push       = w_valid & w_ready;

    // Only a tie consults rr_last; a lone non-empty source always wins.
    assign w_pop[0] = w_nempty[0] & (~w_nempty[1] | r_rr_lsu_last);
    assign w_pop[1] = w_nempty[1] & (~w_nempty[0] | ~r_rr_lsu_last);

    assign w_head_addr = w_pop[1] ? r_mem_addr[1][r_rd_ptr[1]] : r_mem_addr[0][r_rd_ptr[0]];
    assign w_head_data = w_pop[1] ? r_mem_data[1][r_rd_ptr[1]] : r_mem_data[0][r_rd_ptr[0]];

    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (w_push[s]) begin
                r_mem_addr[s][r_wr_ptr[s]] <= w_in_addr[s];
                r_mem_data[s][r_wr_ptr[s]] <= w_in_data[s];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                r_wr_ptr[s] <= '0;
                r_rd_ptr[s] <= '0;
                r_cnt[s]    <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_push[s]) begin
                    r_wr_ptr[s] <= r_wr_ptr[s] + c_PW'(1);
                end
                if (w_pop[s]) begin
                    r_rd_ptr[s] <= r_rd_ptr[s] + c_PW'(1);
                end
                if (w_push[s] && !w_pop[s]) begin
                    r_cnt[s] <= r_cnt[s] + c_CW'(1);
                end else if (!w_push[s] && w_pop[s]) begin
                    r_cnt[s] <= r_cnt[s] - c_CW'(1);
                end
            end
        end
    end

    // x0 writes consume their grant slot but never pulse write_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_lsu_last <= 1'b1;
            r_write_en    <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
        end else begin
            r_write_en <= 1'b0;
            if (|w_pop) begin
                r_rr_lsu_last <= w_pop[1];
                if (w_head_addr != '0) begin
                    r_write_en <= 1'b1;
                    r_wr_addr  <= w_head_addr;
                    r_wr_data  <= w_head_data;
                end
            end
        end
    end

    assign alu_ready     = w_ready[0];
    assign lsu_ready     = w_ready[1];
    assign write_en      = r_write_en;
    assign writereg_addr = r_wr_addr;
    assign write_data    = r_wr_data;
    assign busy          = w_nempty[0] | w_nempty[1] | r_write_en;

`ifdef REGFILE_WR_BYPASS_EN
    logic [1:0] w_pend;

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        w_pend = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ({1'b0, c_PW'(i) - r_rd_ptr[s]} < r_cnt[s]) begin
                    if (r_mem_addr[s][i] == rd_addr1) w_pend[0] = 1'b1;
                    if (r_mem_addr[s][i] == rd_addr2) w_pend[1] = 1'b1;
                end
            end
        end
        if (rd_addr1 == '0) w_pend[0] = 1'b0;
        if (rd_addr2 == '0) w_pend[1] = 1'b0;
    end

    assign pend1     = w_pend[0];
    assign pend2     = w_pend[1];
    assign fwd_hit1  = r_write_en && (r_wr_addr == rd_addr1) && (rd_addr1 != '0);
    assign fwd_hit2  = r_write_en && (r_wr_addr == rd_addr2) && (rd_addr2 != '0);
    assign fwd_data1 = r_wr_data;
    assign fwd_data2 = r_wr_data;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^{rd_addr1, rd_addr2};
    assign pend1       = 1'b0;
    assign pend2       = 1'b0;
    assign fwd_hit1    = 1'b0;
    assign fwd_hit2    = 1'b0;
    assign fwd_data1   = '0;
    assign fwd_data2   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_write_arbiter
//  Purpose  : Self-checking bench: directed vector table, corner sequences and
//             randomized traffic against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;
    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;
`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid = 1'b0, lsu_valid = 1'b0;
    logic [AW-1:0] alu_addr = '0, lsu_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
    logic [DW-1:0] alu_data = '0, lsu_data = '0;
    logic          alu_ready, lsu_ready, write_en, busy;
    logic [AW-1:0] writereg_addr;
    logic [DW-1:0] write_data, fwd_data1, fwd_data2;
    logic          fwd_hit1, fwd_hit2, pend1, pend2;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .write_en(write_en), .writereg_addr(writereg_addr), .write_data(write_data), .busy(busy),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .pend1(pend1), .pend2(pend2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
    endtask

    // ---------------- reference model: two queues plus a fairness flag ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq_alu[$];
    ent_t          mq_lsu[$];
    bit            m_lsu_last;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    task automatic model_reset();
        mq_alu.delete();
        mq_lsu.delete();
        m_lsu_last = 1'b1;
        m_we       = 1'b0;
        m_addr     = '0;
        m_data     = '0;
    endtask

    task automatic model_step();
        bit   acc_a, acc_l, ga, gl;
        ent_t e;
        acc_a = alu_valid && (mq_alu.size() < DEPTH);
        acc_l = lsu_valid && (mq_lsu.size() < DEPTH);
        if (mq_alu.size() != 0 && mq_lsu.size() != 0) begin
            ga = m_lsu_last;
            gl = !m_lsu_last;
        end else begin
            ga = (mq_alu.size() != 0);
            gl = (mq_lsu.size() != 0);
        end
        m_we = 1'b0;
        e    = '0;
        if (ga) begin e = mq_alu.pop_front(); m_lsu_last = 1'b0; end
        if (gl) begin e = mq_lsu.pop_front(); m_lsu_last = 1'b1; end
        if ((ga || gl) && e.a != 0) begin
            m_we   = 1'b1;
            m_addr = e.a;
            m_data = e.d;
        end
        if (acc_a) mq_alu.push_back({alu_addr, alu_data});
        if (acc_l) mq_lsu.push_back({lsu_addr, lsu_data});
    endtask

    function automatic bit m_pend(input logic [AW-1:0] rd);
        if (rd == 0) return 1'b0;
        foreach (mq_alu[i]) if (mq_alu[i].a == rd) return 1'b1;
        foreach (mq_lsu[i]) if (mq_lsu[i].a == rd) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_model();
        chk("rnd_write_en", write_en, m_we);
        chk("rnd_addr", writereg_addr, m_addr);
        chk("rnd_data", write_data, m_data);
        chk("rnd_alu_ready", alu_ready, mq_alu.size() < DEPTH);
        chk("rnd_lsu_ready", lsu_ready, mq_lsu.size() < DEPTH);
        chk("rnd_busy", busy, (mq_alu.size() != 0) || (mq_lsu.size() != 0) || m_we);
        chk("rnd_pend1", pend1, BYP && m_pend(rd_addr1));
        chk("rnd_pend2", pend2, BYP && m_pend(rd_addr2));
        chk("rnd_hit1", fwd_hit1, BYP && m_we && m_addr == rd_addr1 && rd_addr1 != 0);
        chk("rnd_hit2", fwd_hit2, BYP && m_we && m_addr == rd_addr2 && rd_addr2 != 0);
        chk("rnd_fdata1", fwd_data1, BYP ? m_data : '0);
        chk("rnd_fdata2", fwd_data2, BYP ? m_data : '0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        bit            lv;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        bit            ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edata;
        bit            ear;
        bit            elr;
        bit            ebusy;
    } vec_t;

    function automatic vec_t mk(input bit av, input int aa, input int ad,
                                input bit lv, input int la, input int ld,
                                input bit ewe, input int ea, input int ed,
                                input bit ear, input bit elr, input bit eb);
        vec_t v;
        v.av = av; v.aa = AW'(aa); v.ad = DW'(ad);
        v.lv = lv; v.la = AW'(la); v.ld = DW'(ld);
        v.ewe = ewe; v.eaddr = AW'(ea); v.edata = DW'(ed);
        v.ear = ear; v.elr = elr; v.ebusy = eb;
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        tbl[0]  = mk(1, 3, 'hA5, 0, 0, 0,     0, 0, 0,     1, 1, 1);
        tbl[1]  = mk(0, 0, 0,    0, 0, 0,     1, 3, 'hA5,  1, 1, 1);
        tbl[2]  = mk(1, 1, 'h11, 1, 2, 'h22,  0, 3, 'hA5,  1, 1, 1);
        tbl[3]  = mk(0, 0, 0,    0, 0, 0,     1, 2, 'h22,  1, 1, 1);
        tbl[4]  = mk(0, 0, 0,    0, 0, 0,     1, 1, 'h11,  1, 1, 1);
        tbl[5]  = mk(1, 0, 'hFF, 0, 0, 0,     0, 1, 'h11,  1, 1, 1);
        tbl[6]  = mk(0, 0, 0,    0, 0, 0,     0, 1, 'h11,  1, 1, 0);
        tbl[7]  = mk(0, 0, 0,    0, 0, 0,     0, 1, 'h11,  1, 1, 0);
        tbl[8]  = mk(1, 4, 'h44, 1, 6, 'h66,  0, 1, 'h11,  1, 1, 1);
        tbl[9]  = mk(1, 7, 'h77, 0, 0, 0,     1, 6, 'h66,  0, 1, 1);
        tbl[10] = mk(1, 8, 'h88, 0, 0, 0,     1, 4, 'h44,  1, 1, 1);
        tbl[11] = mk(0, 0, 0,    0, 0, 0,     1, 7, 'h77,  1, 1, 1);
        tbl[12] = mk(0, 0, 0,    0, 0, 0,     0, 7, 'h77,  1, 1, 0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_write_en", write_en, 1'b0);
        chk("rst_addr", writereg_addr, '0);
        chk("rst_data", write_data, '0);
        chk("rst_alu_ready", alu_ready, 1'b1);
        chk("rst_lsu_ready", lsu_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);

        // Directed table: latency, rr tie-break, x0 drop, full FIFO refusal
        foreach (tbl[i]) begin
            alu_valid = tbl[i].av; alu_addr = tbl[i].aa; alu_data = tbl[i].ad;
            lsu_valid = tbl[i].lv; lsu_addr = tbl[i].la; lsu_data = tbl[i].ld;
            tick();
            idle();
            chk($sformatf("tbl%0d_write_en", i), write_en, tbl[i].ewe);
            chk($sformatf("tbl%0d_addr", i), writereg_addr, tbl[i].eaddr);
            chk($sformatf("tbl%0d_data", i), write_data, tbl[i].edata);
            chk($sformatf("tbl%0d_alu_ready", i), alu_ready, tbl[i].ear);
            chk($sformatf("tbl%0d_lsu_ready", i), lsu_ready, tbl[i].elr);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
        end

        // After reset the ALU wins the first tie
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_addr = 5'd2; lsu_data = 32'h22;
        tick();
        idle();
        chk("tie_cycle0_we", write_en, 1'b0);
        tick();
        chk("tie_first_we", write_en, 1'b1);
        chk("tie_first_addr", writereg_addr, 5'd1);
        tick();
        chk("tie_second_we", write_en, 1'b1);
        chk("tie_second_addr", writereg_addr, 5'd2);
        chk("tie_second_data", write_data, 32'h22);
        tick();
        chk("tie_done_we", write_en, 1'b0);

        // Asynchronous reset while entries are queued and a write is in flight
        alu_valid = 1'b1; alu_addr = 5'd9;  alu_data = 32'h99;
        lsu_valid = 1'b1; lsu_addr = 5'd10; lsu_data = 32'hAA;
        tick();
        lsu_valid = 1'b0;
        alu_addr = 5'd11; alu_data = 32'hBB;
        tick();
        idle();
        chk("pre_rst_we", write_en, 1'b1);
        chk("pre_rst_addr", writereg_addr, 5'd9);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_we", write_en, 1'b0);
        chk("async_rst_addr", writereg_addr, '0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_alu_ready", alu_ready, 1'b1);
        chk("async_rst_lsu_ready", lsu_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post_rst%0d_we", k), write_en, 1'b0);
        end

        // Bypass and pending indications
        rd_addr1 = 5'd5;
        rd_addr2 = 5'd5;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h77;
        tick();
        idle();
        chk("byp_pend1", pend1, BYP);
        chk("byp_queued_hit1", fwd_hit1, 1'b0);
        tick();
        chk("byp_we", write_en, 1'b1);
        chk("byp_hit1", fwd_hit1, BYP);
        chk("byp_hit2", fwd_hit2, BYP);
        chk("byp_fdata1", fwd_data1, BYP ? 32'h77 : 32'h0);
        chk("byp_pend1_after_pop", pend1, 1'b0);
        rd_addr1 = 5'd0;
        #1;
        chk("byp_x0_hit1", fwd_hit1, 1'b0);
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        tick();

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            lsu_valid = ($urandom_range(0, 99) < 60);
            alu_addr  = AW'($urandom_range(0, 7));
            lsu_addr  = AW'($urandom_range(0, 7));
            alu_data  = $urandom;
            lsu_data  = $urandom;
            rd_addr1  = AW'($urandom_range(0, 7));
            rd_addr2  = AW'($urandom_range(0, 7));
            model_step();
            tick();
            check_model();
        end
        idle();
        for (int c = 0; c < 6; c++) begin
            model_step();
            tick();
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
